sic1_memory_v2: RTL and testbench
=================================

Name: sic1_memory_v2

Overview:
Parametrised successor to the SIC1 memory block. It provides byte-addressed memory built as a flop array of (2^ADDR_W / WORD_BYTES) words of 8*WORD_BYTES bits, with two registered read ports, instruction-field extraction and a byte-lane read tap. Memory-mapped I/O uses proper handshakes: a one-byte input holding register (valid/ready plus explicit pop) and an OUT_DEPTH output FIFO (valid/ready), with backpressure to the CPU through wr_ready. It sits between the SIC1 core FSM and the chip I/O pins.

Parameters:
ADDR_W, 8, byte address width; byte space is 2^ADDR_W.
WORD_BYTES, 4, bytes per memory word; legal values 2, 4, 8. WORD_W = 8*WORD_BYTES, WA = ADDR_W - log2(WORD_BYTES), LW = log2(WORD_BYTES).
ADDR_IN, 2^ADDR_W-3, byte address of the input port.
ADDR_OUT, 2^ADDR_W-2, byte address of the output port.
OUT_DEPTH, 2, output FIFO depth; power of two, at least 2.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  byte write request
wr_addr  in  ADDR_W  byte write address
wr_byte  in  8  write data
wr_ready  out  1  write accepted this edge when wr_en & wr_ready
ra_addr  in  WA  read port A word address
ra_data  out  WORD_W  read port A data (I/O-substituted)
rb_addr  in  WA  read port B word address
rb_data  out  WORD_W  read port B data (I/O-substituted)
pc_low  in  LW  byte offset of instruction within word A
out_a, out_b, out_c  out  8 each  instruction operand bytes
rb_byte_idx  in  LW  byte-lane select on port B
rb_byte  out  8  selected byte of rb_data
in_data  in  8  input byte
in_valid  in  1  input byte offered
in_ready  out  1  holding register empty
in_pop  in  1  CPU consumed the input byte
out_data  out  8  FIFO head byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  sink accepts head

Behaviour:
- Reset (async assert, sync-safe release) clears all memory words to 0, read registers to 0, in_full=0, FIFO count/pointers=0. Outputs after reset: ra_data=rb_data=0, out_a/b/c=0, rb_byte=0, in_ready=1, out_valid=0, out_data=0, wr_ready=1.
- Reads: one-cycle latency. ra_data/rb_data at cycle n+1 reflect the word at the address sampled at edge n. A read during a same-edge write to the same word returns the OLD word. The write is visible from the next read.
- I/O substitution: special flags are registered alongside the read address. When the word read contains ADDR_IN, its lane (ADDR_IN mod WORD_BYTES) returns in_hold if in_full, else 8'h00. Lanes above it read 0. Lanes below it read from memory.
- Writes: byte-lane write enable only, no read-modify-write, so there is no ordering restriction on reads. The write is accepted when wr_en & wr_ready. Every accepted write updates the memory byte, including ADDR_IN and ADDR_OUT.
- wr_ready = ~(wr_addr==ADDR_OUT && fifo_full). It is combinational and independent of a same-cycle FIFO pop. Writes to any other address are always ready.
- Output FIFO: an accepted write to ADDR_OUT pushes wr_byte. A pop occurs on out_valid & out_ready. Push and pop in the same cycle when not full: count unchanged, data order preserved. Pointers wrap modulo OUT_DEPTH. out_data is driven from the head entry and is stable while out_valid & ~out_ready.
- Input: the byte is captured when in_valid & in_ready, then in_full=1. in_pop clears in_full the next edge. in_pop while empty is ignored. Because in_ready=~in_full, a pop and an accept never coincide; the accept happens the cycle after the pop at the earliest.
- Instruction fields: {out_c,out_b,out_a} = low 24 bits of ({rb_data,ra_data} >> 8*pc_low). pc_low=WORD_BYTES-1 spans into word B.
- rb_byte = rb_data lane rb_byte_idx.
- Reset mid-operation drops FIFO contents and the held input byte. out_valid falls asynchronously.

Test Plan:
- Reset: hold rst_n=0 mid-traffic -> all outputs at reset values immediately; in_ready=1, out_valid=0, and every word reads 0 after release.
- Byte write/latency: write 0xAB to addr 0x05, read ra_addr=1 -> ra_data=0x0000AB00 one cycle after the address; a same-edge read returns the old 0x00000000.
- Input: offer in_data=0x5A with in_valid -> in_ready falls; reading word 63 (defaults) -> 0x00005Axx, where xx is the memory byte at address 252. After in_pop, the lane reads 0x00 and in_ready=1.
- Output backpressure: out_ready=0, write 0x11, 0x22, 0x33 to ADDR_OUT -> third write stalls with wr_ready=0. Raise out_ready -> 0x11, 0x22, 0x33 emerge in order, with no loss or duplication.
- Simultaneous push and pop with count=1 -> count stays 1 and order is preserved across pointer wrap (8+ bytes streamed).
- Instruction extraction: word0=0x44332211, word1=0x88776655, pc_low=3 -> out_a=0x44, out_b=0x55, out_c=0x66. Also rb_byte_idx=2 -> rb_byte=0x77.

Source files
------------

// File: rtl/sic1_memory_v2.sv
// Parametrised SIC1 memory: byte-addressed flop array with two registered read ports,
// instruction-field extraction, an input holding register and an output FIFO.
module sic1_memory_v2 #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_IN    = (1 << ADDR_W) - 3,
  parameter int ADDR_OUT   = (1 << ADDR_W) - 2,
  parameter int OUT_DEPTH  = 2,
  localparam int WORD_W    = 8 * WORD_BYTES,
  localparam int LW        = $clog2(WORD_BYTES),
  localparam int WA        = ADDR_W - LW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_byte,
  output logic              wr_ready,
  input  logic [WA-1:0]     ra_addr,
  output logic [WORD_W-1:0] ra_data,
  input  logic [WA-1:0]     rb_addr,
  output logic [WORD_W-1:0] rb_data,
  input  logic [LW-1:0]     pc_low,
  output logic [7:0]        out_a,
  output logic [7:0]        out_b,
  output logic [7:0]        out_c,
  input  logic [LW-1:0]     rb_byte_idx,
  output logic [7:0]        rb_byte,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_pop,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int NWORDS = 1 << WA;
  localparam int PW     = $clog2(OUT_DEPTH);
  localparam int IN_LANE = ADDR_IN % WORD_BYTES;
  localparam logic [WA-1:0]     IN_WORD  = WA'(ADDR_IN >> LW);
  localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(ADDR_OUT);

  logic [WORD_W-1:0] mem [NWORDS];
  logic [WORD_W-1:0] ra_word;
  logic [WORD_W-1:0] rb_word;
  logic              ra_special;
  logic              rb_special;
  logic              in_full;
  logic [7:0]        in_hold;
  logic [7:0]        fifo [OUT_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  logic              fifo_full;
  logic              wr_accept;
  logic              push;
  logic              pop;
  logic [WA-1:0]     wr_word;
  logic [LW-1:0]     wr_lane;
  logic [2*WORD_W-1:0] pair;
  logic [23:0]       fields;

  assign wr_word   = wr_addr[ADDR_W-1:LW];
  assign wr_lane   = wr_addr[LW-1:0];
  assign fifo_full = (count == (PW+1)'(OUT_DEPTH));
  assign wr_ready  = !((wr_addr == OUT_ADDR) && fifo_full);
  assign wr_accept = wr_en && wr_ready;
  assign push      = wr_accept && (wr_addr == OUT_ADDR);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo[head] : 8'h00;
  assign in_ready  = !in_full;

  // Read data is the old word on a same-edge write; only the addressed byte lane is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) begin
        mem[i] <= '0;
      end
      ra_word    <= '0;
      rb_word    <= '0;
      ra_special <= 1'b0;
      rb_special <= 1'b0;
    end else begin
      ra_word    <= mem[ra_addr];
      rb_word    <= mem[rb_addr];
      ra_special <= (ra_addr == IN_WORD);
      rb_special <= (rb_addr == IN_WORD);
      if (wr_accept) begin
        mem[wr_word][{wr_lane, 3'b000} +: 8] <= wr_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[tail] <= wr_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_full <= 1'b0;
      in_hold <= 8'h00;
    end else if (in_valid && in_ready) begin
      in_full <= 1'b1;
      in_hold <= in_data;
    end else if (in_pop) begin
      in_full <= 1'b0;
    end
  end

  function automatic logic [WORD_W-1:0] io_subst(input logic [WORD_W-1:0] word,
                                                 input logic special,
                                                 input logic full,
                                                 input logic [7:0] hold);
    logic [WORD_W-1:0] res;
    res = word;
    if (special) begin
      for (int l = IN_LANE; l < WORD_BYTES; l++) begin
        res[8*l +: 8] = ((l == IN_LANE) && full) ? hold : 8'h00;
      end
    end
    return res;
  endfunction

  assign ra_data = io_subst(ra_word, ra_special, in_full, in_hold);
  assign rb_data = io_subst(rb_word, rb_special, in_full, in_hold);

  // An instruction at the last byte of word A continues into word B.
  assign pair   = {rb_data, ra_data};
  assign fields = pair[{pc_low, 3'b000} +: 24];
  assign {out_c, out_b, out_a} = fields;
  assign rb_byte = rb_data[{rb_byte_idx, 3'b000} +: 8];

endmodule

// File: tb/tb_sic1_memory_v2.sv
// Bench for sic1_memory_v2: byte-level behavioural model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_sic1_memory_v2;

  localparam int ADDR_IN   = 253;
  localparam int ADDR_OUT  = 254;
  localparam int OUT_DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_byte;
  logic        wr_ready;
  logic [5:0]  ra_addr;
  logic [31:0] ra_data;
  logic [5:0]  rb_addr;
  logic [31:0] rb_data;
  logic [1:0]  pc_low;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [7:0]  out_c;
  logic [1:0]  rb_byte_idx;
  logic [7:0]  rb_byte;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_pop;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 0;

  logic [7:0]  m_mem [256];
  logic [7:0]  m_q [$];
  logic        m_full = 1'b0;
  logic [7:0]  m_hold = 8'h00;
  int          m_ra_sel = 0;
  int          m_rb_sel = 0;
  logic [31:0] m_ra_raw = '0;
  logic [31:0] m_rb_raw = '0;
  logic [7:0]  popped [$];

  sic1_memory_v2 #(
    .ADDR_W(8), .WORD_BYTES(4), .ADDR_IN(ADDR_IN), .ADDR_OUT(ADDR_OUT), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_byte(wr_byte), .wr_ready(wr_ready),
    .ra_addr(ra_addr), .ra_data(ra_data), .rb_addr(rb_addr), .rb_data(rb_data),
    .pc_low(pc_low), .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .rb_byte_idx(rb_byte_idx), .rb_byte(rb_byte),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_pop(in_pop),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int w);
    return {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
  endfunction

  // Byte-address view: the input port byte is live, bytes after it in its word read 0.
  function automatic logic [31:0] exp_word(input int sel, input logic [31:0] raw);
    logic [31:0] r;
    logic [7:0]  b;
    int          a;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      a = sel * 4 + l;
      b = raw[8*l +: 8];
      if (a == ADDR_IN) b = m_full ? m_hold : 8'h00;
      else if (a > ADDR_IN && (a / 4) == (ADDR_IN / 4)) b = 8'h00;
      r = r | (32'(b) << (8 * l));
    end
    return r;
  endfunction

  task automatic model_step();
    logic ready;
    logic pop;
    logic push;
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      m_q.delete();
      m_full = 1'b0;
      m_hold = 8'h00;
      m_ra_sel = 0;
      m_rb_sel = 0;
      m_ra_raw = '0;
      m_rb_raw = '0;
      return;
    end
    ready = !(int'(wr_addr) == ADDR_OUT && m_q.size() == OUT_DEPTH);
    pop   = (m_q.size() != 0) && out_ready;
    push  = wr_en && ready && int'(wr_addr) == ADDR_OUT;
    m_ra_raw = word_of(int'(ra_addr));
    m_rb_raw = word_of(int'(rb_addr));
    m_ra_sel = int'(ra_addr);
    m_rb_sel = int'(rb_addr);
    if (wr_en && ready) m_mem[wr_addr] = wr_byte;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(wr_byte);
    if (in_valid && !m_full) begin
      m_full = 1'b1;
      m_hold = in_data;
    end else if (in_pop && m_full) begin
      m_full = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  task automatic compare_all();
    logic [31:0] ra_e;
    logic [31:0] rb_e;
    logic [63:0] sh;
    ra_e = exp_word(m_ra_sel, m_ra_raw);
    rb_e = exp_word(m_rb_sel, m_rb_raw);
    sh   = {rb_e, ra_e} >> (8 * int'(pc_low));
    check_output("ra_data", 64'(ra_data), 64'(ra_e));
    check_output("rb_data", 64'(rb_data), 64'(rb_e));
    check_output("out_a", 64'(out_a), sh & 64'hff);
    check_output("out_b", 64'(out_b), (sh >> 8) & 64'hff);
    check_output("out_c", 64'(out_c), (sh >> 16) & 64'hff);
    check_output("rb_byte", 64'(rb_byte), (64'(rb_e) >> (8 * int'(rb_byte_idx))) & 64'hff);
    check_output("in_ready", 64'(in_ready), 64'(!m_full));
    check_output("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check_output("out_data", 64'(out_data), (m_q.size() != 0) ? 64'(m_q[0]) : 64'h0);
    check_output("wr_ready", 64'(wr_ready),
                 64'(!(int'(wr_addr) == ADDR_OUT && m_q.size() == OUT_DEPTH)));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) compare_all();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) popped.push_back(out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_byte = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    int n;
    n = 0;
    wr_en = 1'b1;
    wr_addr = 8'(ADDR_OUT);
    wr_byte = d;
    @(negedge clk);
    while (!wr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("wr_ready_wait", 64'(wr_ready), 64'h1);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic apply_stimulus();
    logic [7:0] stream [$];
    rst_n = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_byte = '0;
    ra_addr = '0; rb_addr = '0; pc_low = '0; rb_byte_idx = '0;
    in_data = '0; in_valid = 1'b0; in_pop = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    check_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_in_ready", 64'(in_ready), 64'h1);
    check_output("rst_out_valid", 64'(out_valid), 64'h0);
    check_output("rst_wr_ready", 64'(wr_ready), 64'h1);
    check_output("rst_ra_data", 64'(ra_data), 64'h0);

    tick();
    wr_en = 1'b1; wr_addr = 8'h05; wr_byte = 8'hAB; ra_addr = 6'd1;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    check_output("same_edge_old", 64'(ra_data), 64'h0);
    tick();
    @(negedge clk);
    check_output("write_visible", 64'(ra_data), 64'h0000AB00);

    tick();
    for (int i = 0; i < 8; i++) write_byte(8'(i), 8'(8'h11 * (i + 1)));
    ra_addr = 6'd0; rb_addr = 6'd1; pc_low = 2'd3; rb_byte_idx = 2'd2;
    tick();
    @(negedge clk);
    check_output("fld3_a", 64'(out_a), 64'h44);
    check_output("fld3_b", 64'(out_b), 64'h55);
    check_output("fld3_c", 64'(out_c), 64'h66);
    check_output("rb_byte2", 64'(rb_byte), 64'h77);
    #1 pc_low = 2'd0;
    #1 check_output("fld0_abc", 64'({out_c, out_b, out_a}), 64'h332211);
    pc_low = 2'd1;
    #1 check_output("fld1_abc", 64'({out_c, out_b, out_a}), 64'h443322);

    tick();
    write_byte(8'd252, 8'hC7);
    write_byte(8'd253, 8'h99);
    write_byte(8'd255, 8'h77);
    in_data = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_output("in_captured", 64'(in_ready), 64'h0);
    tick();
    ra_addr = 6'd63; rb_addr = 6'd63;
    tick();
    @(negedge clk);
    check_output("in_lane_full", 64'(ra_data), 64'h00005AC7);
    tick();
    in_pop = 1'b1;
    tick();
    in_pop = 1'b0;
    @(negedge clk);
    check_output("in_popped_ready", 64'(in_ready), 64'h1);
    check_output("in_lane_empty", 64'(ra_data), 64'h000000C7);
    tick();
    in_pop = 1'b1;
    tick();
    in_pop = 1'b0;
    in_data = 8'h3C; in_valid = 1'b1;
    tick();
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_output("in_full_ignores", 64'(ra_data), 64'h00003CC7);
    tick();
    in_pop = 1'b1;
    tick();
    in_pop = 1'b0;

    out_ready = 1'b0;
    popped.delete();
    push_byte(8'h11);
    push_byte(8'h22);
    wr_en = 1'b1; wr_addr = 8'(ADDR_OUT); wr_byte = 8'h33;
    @(negedge clk);
    check_output("full_stall", 64'(wr_ready), 64'h0);
    check_output("full_head", 64'(out_data), 64'h11);
    tick();
    out_ready = 1'b1;
    push_byte(8'h33);
    repeat (4) tick();
    check_output("bp_count", 64'(popped.size()), 64'd3);
    stream = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3 && i < popped.size(); i++)
      check_output("bp_order", 64'(popped[i]), 64'(stream[i]));

    popped.delete();
    for (int k = 0; k < 10; k++) push_byte(8'hA0 + 8'(k));
    repeat (3) tick();
    check_output("stream_count", 64'(popped.size()), 64'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      check_output("stream_order", 64'(popped[i]), 64'hA0 + 64'(i));

    out_ready = 1'b0;
    push_byte(8'h5E);
    in_data = 8'h61; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_out_valid", 64'(out_valid), 64'h0);
    check_output("midrst_out_data", 64'(out_data), 64'h0);
    check_output("midrst_in_ready", 64'(in_ready), 64'h1);
    check_output("midrst_ra_data", 64'(ra_data), 64'h0);
    check_output("midrst_wr_ready", 64'(wr_ready), 64'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int w = 0; w < 64; w++) begin
      ra_addr = 6'(w);
      rb_addr = 6'(63 - w);
      tick();
      @(negedge clk);
      check_output("post_rst_word", 64'(ra_data), 64'h0);
      tick();
    end
    tick();
    @(negedge clk);
    check_en = 1'b0;
  endtask

  initial begin
    apply_stimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: stimulus did not complete, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
